// File: rtl/tick_period_meter.sv
// tick_period_meter: measures clocks between rising edges of an asynchronous tick,
// with valid/ack handshake, sticky overrun and a stalled flag on counter saturation.
`default_nettype none

module tick_period_meter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             tick_in,
  input  logic             rd_ack,
  output logic [WIDTH-1:0] period,
  output logic             valid,
  output logic             overrun,
  output logic             stalled
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] MEASURE = 2'd1;
  localparam logic [1:0] STALL   = 2'd2;

  localparam logic [WIDTH-1:0] COUNT_MAX = '1;
  localparam logic [WIDTH-1:0] COUNT_ONE = WIDTH'(1);

  logic             s0_q, s1_q, s2_q;
  logic             tick_rise;
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             stalled_q, stalled_d;
  logic             complete;

  assign tick_rise = s1_q & ~s2_q;

  // State register, synchronizer and history flop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s0_q    <= 1'b0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= IDLE;
    end else begin
      s0_q    <= tick_in;
      s1_q    <= s0_q;
      s2_q    <= s1_q;
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tick_rise) state_d = MEASURE;
      MEASURE: if (!tick_rise && count_q == COUNT_MAX) state_d = STALL;
      STALL:   if (tick_rise) state_d = MEASURE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d   = count_q;
    period_d  = period_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    stalled_d = stalled_q;
    complete  = 1'b0;

    case (state_q)
      IDLE: begin
        if (tick_rise) count_d = COUNT_ONE;
      end
      MEASURE: begin
        if (tick_rise) begin
          complete = 1'b1;
          count_d  = COUNT_ONE;
        end else if (count_q == COUNT_MAX) begin
          stalled_d = 1'b1;
        end else begin
          count_d = count_q + COUNT_ONE;
        end
      end
      STALL: begin
        if (tick_rise) begin
          count_d   = COUNT_ONE;
          stalled_d = 1'b0;
        end
      end
      default: count_d = '0;
    endcase

    if (rd_ack && valid_q) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end

    // A completion outranks a simultaneous ack; overrun only if the old value went unread.
    if (complete) begin
      period_d  = count_q;
      valid_d   = 1'b1;
      overrun_d = valid_q & ~rd_ack;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q   <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      stalled_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      stalled_q <= stalled_d;
    end
  end

  assign period  = period_q;
  assign valid   = valid_q;
  assign overrun = overrun_q;
  assign stalled = stalled_q;

endmodule

`default_nettype wire

// File: tb/tb_tick_period_meter.sv
// tb_tick_period_meter: scenario tasks drive ticks; a reference model queues expected
// results with their due cycle and a negedge monitor compares them against the DUT.
`default_nettype none

module tb_tick_period_meter;

  localparam int W    = 4;
  localparam int MAXP = 15;

  logic         clock   = 1'b0;
  logic         reset_n = 1'b1;
  logic         tick_in = 1'b0;
  logic         rd_ack  = 1'b0;
  logic [W-1:0] period;
  logic         valid, overrun, stalled;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int due_q[$];
  int per_q[$];
  bit armed      = 1'b0;
  int last_edge  = 0;
  bit valid_prev = 1'b0;

  tick_period_meter #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .tick_in (tick_in),
    .rd_ack  (rd_ack),
    .period  (period),
    .valid   (valid),
    .overrun (overrun),
    .stalled (stalled)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (reset_n) begin
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        int exp_p;
        exp_p = per_q.pop_front();
        void'(due_q.pop_front());
        checks++;
        if (valid !== 1'b1 || int'(period) !== exp_p) begin
          errors++;
          $display("FAIL sb_result cyc=%0d got valid=%b period=%0d, want valid=1 period=%0d",
                   cyc, valid, period, exp_p);
        end
      end else if (valid === 1'b1 && !valid_prev) begin
        checks++;
        errors++;
        $display("FAIL sb_spurious_valid cyc=%0d got valid=1 period=%0d, want no new result",
                 cyc, period);
      end
    end
    valid_prev = (valid === 1'b1);
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout at cyc=%0d, want completion", cyc);
    $fatal(1, "timeout");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_neg(input int target);
    repeat (target - cyc) @(posedge clock);
    @(negedge clock);
  endtask

  // Reference model: an edge completes a period only if armed and within MAXP of the last edge.
  task automatic rise();
    int k;
    k = cyc + 1;
    tick_in = 1'b1;
    if (armed && (k - last_edge) <= MAXP) begin
      due_q.push_back(k + 2);
      per_q.push_back(k - last_edge);
    end
    armed     = 1'b1;
    last_edge = k;
  endtask

  task automatic pulse(input int hi, input int lo);
    rise();
    step(hi);
    tick_in = 1'b0;
    step(lo);
  endtask

  task automatic ack();
    rd_ack = 1'b1;
    step(1);
    rd_ack = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (period !== '0 || valid !== 1'b0 || overrun !== 1'b0 || stalled !== 1'b0) begin
      errors++;
      $display("FAIL reset_values got p=%0d v=%b o=%b s=%b, want all 0", period, valid, overrun, stalled);
    end
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    armed   = 1'b0;
    step(2);
  endtask

  task automatic test_square10();
    int k2;
    pulse(5, 5);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL sq10_first_edge got valid=%b, want 0", valid);
    end
    rise();
    k2 = last_edge;
    wait_neg(k2 + 1);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL sq10_early_valid got valid=%b at edge+1, want 0", valid);
    end
    step(4);
    tick_in = 1'b0;
    step(5);
    ack();
    checks++;
    if (valid !== 1'b0 || overrun !== 1'b0 || int'(period) !== 10) begin
      errors++;
      $display("FAIL sq10_ack got v=%b o=%b p=%0d, want v=0 o=0 p=10", valid, overrun, period);
    end
    step(20);
  endtask

  task automatic test_overrun7();
    repeat (4) pulse(4, 3);
    checks++;
    if (int'(period) !== 7 || valid !== 1'b1 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr7_flags got p=%0d v=%b o=%b, want p=7 v=1 o=1", period, valid, overrun);
    end
    ack();
    checks++;
    if (int'(period) !== 7 || valid !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr7_ack got p=%0d v=%b o=%b, want p=7 v=0 o=0", period, valid, overrun);
    end
    step(20);
  endtask

  task automatic test_stall();
    int kb;
    pulse(8, 7);
    rise();
    kb = last_edge;
    step(8);
    tick_in = 1'b0;
    step(4);
    checks++;
    if (int'(period) !== MAXP || valid !== 1'b1 || stalled !== 1'b0) begin
      errors++;
      $display("FAIL stall_max_period got p=%0d v=%b s=%b, want p=15 v=1 s=0", period, valid, stalled);
    end
    ack();
    step(3);
    rise();
    wait_neg(kb + 16);
    checks++;
    if (stalled !== 1'b0) begin
      errors++;
      $display("FAIL stall_early got stalled=%b at 14 clocks, want 0", stalled);
    end
    wait_neg(kb + 17);
    checks++;
    if (stalled !== 1'b1) begin
      errors++;
      $display("FAIL stall_rise got stalled=%b at 15 clocks, want 1", stalled);
    end
    wait_neg(kb + 18);
    checks++;
    if (stalled !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_clear got s=%b v=%b, want s=0 v=0", stalled, valid);
    end
    step(3);
    tick_in = 1'b0;
    step(20);
  endtask

  task automatic test_ack_collision();
    pulse(6, 5);
    pulse(6, 5);
    pulse(6, 6);
    rise();
    step(2);
    checks++;
    if (valid !== 1'b1 || overrun !== 1'b1 || int'(period) !== 11) begin
      errors++;
      $display("FAIL coll_pre got v=%b o=%b p=%0d, want v=1 o=1 p=11", valid, overrun, period);
    end
    rd_ack = 1'b1;
    step(1);
    rd_ack = 1'b0;
    checks++;
    if (valid !== 1'b1 || overrun !== 1'b0 || int'(period) !== 12) begin
      errors++;
      $display("FAIL coll_post got v=%b o=%b p=%0d, want v=1 o=0 p=12", valid, overrun, period);
    end
    step(4);
    tick_in = 1'b0;
    step(6);
    ack();
    step(20);
  endtask

  task automatic test_async_reset();
    pulse(5, 4);
    pulse(5, 4);
    step(20);
    checks++;
    if (valid !== 1'b1 || stalled !== 1'b1) begin
      errors++;
      $display("FAIL arst_pre got v=%b s=%b, want v=1 s=1", valid, stalled);
    end
    @(negedge clock);
    #3 reset_n = 1'b0;
    due_q.delete();
    per_q.delete();
    armed = 1'b0;
    #1;
    checks++;
    if (period !== '0 || valid !== 1'b0 || overrun !== 1'b0 || stalled !== 1'b0) begin
      errors++;
      $display("FAIL arst_immediate got p=%0d v=%b o=%b s=%b, want all 0", period, valid, overrun, stalled);
    end
    step(2);
    @(negedge clock);
    reset_n = 1'b1;
    step(1);
    pulse(4, 5);
    pulse(4, 5);
    checks++;
    if (int'(period) !== 9 || valid !== 1'b1 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL arst_after got p=%0d v=%b o=%b, want p=9 v=1 o=0", period, valid, overrun);
    end
    ack();
    step(20);
  endtask

  task automatic test_period2();
    repeat (6) pulse(1, 1);
    step(3);
    checks++;
    if (int'(period) !== 2 || valid !== 1'b1 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL per2 got p=%0d v=%b o=%b, want p=2 v=1 o=1", period, valid, overrun);
    end
    ack();
    step(3);
  endtask

  initial begin
    test_reset();
    test_square10();
    test_overrun7();
    test_stall();
    test_ack_collision();
    test_async_reset();
    test_period2();
    checks++;
    if (due_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d pending results, want 0", due_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
